// File: rtl/animador_estados.sv
// Animation sequencer: turns the controller's estado into sprite/frame
// selection. Looping states cycle frames forever, one-shot states play once
// and pulse fim_animacao, MORTO shows a static frame.
module animador_estados #(
   parameter int unsigned CICLOS_POR_QUADRO = 12_500_000,
   parameter int unsigned QUADROS_LOOP      = 4,
   parameter int unsigned QUADROS_UNICA     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] estado,
   output logic [2:0] sprite,
   output logic [3:0] quadro,
   output logic       fim_animacao,
   output logic       ocupado
);

   localparam int unsigned TW = $clog2(CICLOS_POR_QUADRO);

   localparam logic [TW-1:0] TIMER_ULT = TW'(CICLOS_POR_QUADRO - 1);
   localparam logic [3:0]    LOOP_ULT  = 4'(QUADROS_LOOP - 1);
   localparam logic [3:0]    UNICA_ULT = 4'(QUADROS_UNICA - 1);

   typedef enum logic [1:0] {
      TOCANDO_LOOP,
      TOCANDO_UNICA,
      CONCLUIDA,
      PARADO
   } fase_t;

   fase_t         fase_q, fase_d;
   logic [2:0]    sprite_q, sprite_d;
   logic [3:0]    quadro_q, quadro_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          fim_q, fim_d;
   logic          ocupado_q, ocupado_d;
   logic          tick;

   assign tick = (timer_q == TIMER_ULT);

   // Next-state: estado change restarts the animation, otherwise advance by class.
   always_comb begin
      fase_d    = fase_q;
      sprite_d  = sprite_q;
      quadro_d  = quadro_q;
      timer_d   = timer_q;
      fim_d     = 1'b0;
      ocupado_d = ocupado_q;

      if (estado != sprite_q) begin
         sprite_d  = estado;
         quadro_d  = '0;
         timer_d   = '0;
         ocupado_d = 1'b0;
         case (estado)
            3'b010, 3'b100, 3'b110: begin
               fase_d    = TOCANDO_UNICA;
               ocupado_d = 1'b1;
            end
            3'b111:  fase_d = PARADO;
            default: fase_d = TOCANDO_LOOP;
         endcase
      end else begin
         case (fase_q)
            TOCANDO_LOOP: begin
               timer_d = tick ? '0 : timer_q + 1'b1;
               if (tick) begin
                  quadro_d = (quadro_q >= LOOP_ULT) ? '0 : quadro_q + 4'd1;
               end
            end
            TOCANDO_UNICA: begin
               timer_d = tick ? '0 : timer_q + 1'b1;
               if (tick) begin
                  if (quadro_q >= UNICA_ULT) begin
                     fim_d     = 1'b1;
                     ocupado_d = 1'b0;
                     fase_d    = CONCLUIDA;
                     timer_d   = '0;
                  end else begin
                     quadro_d = quadro_q + 4'd1;
                  end
               end
            end
            CONCLUIDA: begin
               timer_d   = '0;
               ocupado_d = 1'b0;
            end
            PARADO: begin
               quadro_d  = '0;
               timer_d   = '0;
               ocupado_d = 1'b0;
            end
            default: fase_d = TOCANDO_LOOP;
         endcase
      end
   end

   // State register with synchronous reset back to the IDLE loop.
   always_ff @(posedge clk) begin
      if (rst) begin
         fase_q    <= TOCANDO_LOOP;
         sprite_q  <= '0;
         quadro_q  <= '0;
         timer_q   <= '0;
         fim_q     <= 1'b0;
         ocupado_q <= 1'b0;
      end else begin
         fase_q    <= fase_d;
         sprite_q  <= sprite_d;
         quadro_q  <= quadro_d;
         timer_q   <= timer_d;
         fim_q     <= fim_d;
         ocupado_q <= ocupado_d;
      end
   end

   assign sprite       = sprite_q;
   assign quadro       = quadro_q;
   assign fim_animacao = fim_q;
   assign ocupado      = ocupado_q;

endmodule

// File: doc/animador_estados.md
Name: animador_estados

Overview:
- Animation sequencer on the far side of the main-controller interface.
- Consumes the controller's 3-bit `estado` and produces the sprite/frame selection for the display path.
- Returns `fim_animacao` so the controller can leave the one-shot states: ACORDANDO, LIMPANDO_BOCA and VOLTANDO.
- Loop states cycle frames indefinitely; MORTO shows a static frame.

Parameters:
- CICLOS_POR_QUADRO, 12_500_000, clk cycles per animation frame (4 fps at 50 MHz); minimum 2.
- QUADROS_LOOP, 4, frame count for looping states; range 1..16.
- QUADROS_UNICA, 8, frame count for one-shot states; range 1..16.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- estado  input  3  state code from controller: IDLE=000, DORMINDO=001, ACORDANDO=010, COMENDO=011, LIMPANDO_BOCA=100, DANDO_AULA=101, VOLTANDO=110, MORTO=111.
- sprite  output  3  registered copy of the estado currently being animated.
- quadro  output  4  current frame index within the sprite.
- fim_animacao  output  1  one-cycle pulse: one-shot animation completed.
- ocupado  output  1  high while a one-shot animation is playing.

Behaviour:
- Reset: sprite=000, quadro=0, fim_animacao=0, ocupado=0, frame timer=0, internal FSM=TOCANDO_LOOP (IDLE animation). Reset applies mid-animation with no pulse emitted.
- Internal FSM states: TOCANDO_LOOP, TOCANDO_UNICA, CONCLUIDA, PARADO.
- Change detection:
  - Each cycle, estado is compared with sprite.
  - If they differ, the next edge sets sprite=estado, quadro=0, timer=0 and enters the class FSM state:
    - IDLE, DORMINDO, COMENDO, DANDO_AULA -> TOCANDO_LOOP.
    - ACORDANDO, LIMPANDO_BOCA, VOLTANDO -> TOCANDO_UNICA (ocupado=1 on that same edge).
    - MORTO -> PARADO.
  - Latency from estado change to updated sprite/quadro: 1 cycle.
- Frame timer:
  - Counts 0..CICLOS_POR_QUADRO-1; width clog2(CICLOS_POR_QUADRO).
  - A tick occurs when timer==CICLOS_POR_QUADRO-1; the timer then wraps to 0.
  - Each frame is therefore held exactly CICLOS_POR_QUADRO cycles.
- TOCANDO_LOOP: on tick, quadro increments; quadro==QUADROS_LOOP-1 wraps to 0. QUADROS_LOOP=1 holds quadro=0.
- TOCANDO_UNICA:
  - On tick, quadro increments until QUADROS_UNICA-1.
  - On the tick while quadro==QUADROS_UNICA-1: fim_animacao=1 for the next cycle only, ocupado=0, move to CONCLUIDA; quadro holds the last frame.
- CONCLUIDA: timer stopped, quadro holds, fim_animacao=0. Stays here until estado changes (controller answers with IDLE).
- PARADO: quadro=0, timer held at 0, ocupado=0; left only on estado change.
- Simultaneous estado change and final tick: the change wins, there is no fim_animacao pulse, and the new sprite starts at frame 0.
- Repeated one-shot (estado leaves and returns to the same one-shot code) restarts from frame 0 and pulses again.
- fim_animacao is never asserted for more than one cycle and never asserted in loop/PARADO states.
- All outputs are registered; there is no combinational path from estado to outputs.

Test Plan (CICLOS_POR_QUADRO=4, QUADROS_LOOP=2, QUADROS_UNICA=3):
- Reset, hold estado=000 for 20 cycles -> sprite=000; quadro sequence 0,1,0,1,… changing every 4 cycles; fim_animacao and ocupado stay 0.
- Set estado=010 and hold:
  - next cycle: sprite=010, quadro=0, ocupado=1.
  - quadro 0→1→2 at 4-cycle spacing.
  - 12 cycles after entry: fim_animacao=1 for exactly 1 cycle, ocupado=0, quadro stays 2 thereafter.
- While in CONCLUIDA of 100, set estado=000 -> next cycle sprite=000, quadro=0, looping resumes; no extra pulse.
- Change estado 110→000 on the exact cycle of the final tick -> fim_animacao stays 0, sprite=000, quadro=0.
- Set estado=111 -> sprite=111, quadro=0 constant for 50 cycles, ocupado=0; then estado=001 -> loop animation starts at frame 0.
- Assert rst for 1 cycle mid one-shot (quadro=1, ocupado=1) -> next cycle all outputs 0, sprite=000, no fim_animacao.
